// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int unsigned LED_W_DEF = 4;

    // Pointer moves just past the winner so it gets lowest priority next round.
    function automatic int unsigned next_ptr(input int unsigned winner, input int unsigned num);
        return (winner + 1 >= num) ? 0 : winner + 1;
    endfunction

endpackage

// File: rtl/led_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above p, modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      p,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    int unsigned idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(p) + i) % NUM_REQ;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner arbitration of the LED bank with hold-time preemption and idle heartbeat.
// Optional macro LED_ARB_DIM_EN dims the heartbeat to 25% duty.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned LED_W    = LED_W_DEF,
    parameter int unsigned MAX_HOLD = 66_000_000,
    parameter int unsigned HB_W     = 27
) (
    input  logic                     CLK_66MHZ,
    input  logic                     USER_RESET_N,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] pattern,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [LED_W-1:0]         LED
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [HB_W-1:0]    hb_q;
    logic [LED_W-1:0]   led_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_valid;
    int unsigned        win_idx;
    logic [LED_W-1:0]   owner_pat;
    logic               owner_req;
    logic               others_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req   (req),
        .p     (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        win_idx   = 0;
        owner_pat = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) win_idx = i;
            if (grant_q[i])  owner_pat = owner_pat | pattern[i*LED_W +: LED_W];
        end
    end

    assign owner_req  = |(req & grant_q);
    assign others_req = |(req & ~grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE, RELEASE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    grant_d = pick_gnt;
                    ptr_d   = PW'(next_ptr(win_idx, NUM_REQ));
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            GRANT: begin
                // Drop and timeout together still take the single RELEASE cycle.
                if (!owner_req || (hold_q == HOLD_LAST && others_req)) begin
                    state_d = RELEASE;
                    grant_d = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_66MHZ) begin
        if (!USER_RESET_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge CLK_66MHZ) begin
        if (!USER_RESET_N) begin
            hb_q  <= '0;
            led_q <= '0;
        end else begin
            hb_q <= hb_q + 1'b1;
            if (state_q == GRANT) begin
                led_q <= owner_pat;
            end else begin
`ifdef LED_ARB_DIM_EN
                led_q <= (hb_q[1:0] == 2'b00) ? hb_q[HB_W-1 -: LED_W] : '0;
`else
                led_q <= hb_q[HB_W-1 -: LED_W];
`endif
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == GRANT);
    assign LED   = led_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter against an owner/phase reference model.
module tb_led_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int LED_W    = 4;
    localparam int MAX_HOLD = 8;
    localparam int HB_W     = 6;

    logic                     CLK_66MHZ;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] pattern;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic [LED_W-1:0]         LED;

    int vectors;
    int miscompares;

    // Reference model: owner index (-1 = nobody), phase 0 idle / 1 owned / 2 gap cycle.
    int         m_owner;
    int         m_phase;
    int         m_ptr;
    int         m_hold;
    int         m_hb;
    logic [3:0] m_led;

    led_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .LED_W    (LED_W),
        .MAX_HOLD (MAX_HOLD),
        .HB_W     (HB_W)
    ) dut (
        .CLK_66MHZ    (CLK_66MHZ),
        .USER_RESET_N (rst_n),
        .req          (req),
        .pattern      (pattern),
        .grant        (grant),
        .busy         (busy),
        .LED          (LED)
    );

    initial begin
        CLK_66MHZ = 1'b0;
        forever #5 CLK_66MHZ = ~CLK_66MHZ;
    end

    function automatic logic [3:0] exp_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    function automatic logic exp_busy();
        return (m_phase == 1);
    endfunction

    task automatic model_step();
        bit found;
        int c;
        int hbits;
        if (!rst_n) begin
            m_owner = -1; m_phase = 0; m_ptr = 0; m_hold = 0; m_hb = 0; m_led = 4'h0;
        end else begin
            if (m_phase == 1) begin
                m_led = 4'((pattern >> (m_owner * LED_W)) & 16'h000F);
            end else begin
                hbits = m_hb >> (HB_W - LED_W);
`ifdef LED_ARB_DIM_EN
                m_led = (m_hb % 4 == 0) ? 4'(hbits) : 4'h0;
`else
                m_led = 4'(hbits);
`endif
            end
            m_hb = (m_hb + 1) % (1 << HB_W);
            if (m_phase == 1) begin
                if (!req[m_owner] ||
                    (m_hold == MAX_HOLD - 1 && (req & ~4'(1 << m_owner)) != 4'b0)) begin
                    m_phase = 2;
                    m_owner = -1;
                end else if (m_hold < MAX_HOLD - 1) begin
                    m_hold = m_hold + 1;
                end
            end else begin
                found = 0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    c = (m_ptr + i) % NUM_REQ;
                    if (!found && req[c]) begin
                        found   = 1;
                        m_owner = c;
                    end
                end
                if (found) begin
                    m_phase = 1;
                    m_ptr   = (m_owner + 1) % NUM_REQ;
                    m_hold  = 0;
                end else begin
                    m_phase = 0;
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK_66MHZ);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        req = 4'b0001;
        pattern = 16'h000C;
        for (int k = 0; k < 3; k++) tick();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (grant !== 4'b0000 || busy !== 1'b0 || LED !== 4'h0) begin
                miscompares++;
                $display("FAIL reset_hold: grant=%b busy=%b LED=%h want 0000/0/0", grant, busy, LED);
            end
        end
        rst_n = 1'b1;
        req = '0;
        for (int k = 0; k < 70; k++) begin
            tick();
            vectors++;
            if (LED !== m_led || grant !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_heartbeat: LED=%h grant=%b want %h/0000", LED, grant, m_led);
            end
        end
    endtask

    task automatic test_single_grant();
        apply_reset();
        pattern = {$urandom} & 32'hFFFF;
        pattern[11:8] = 4'hA;
        req = 4'b0100;
        tick();
        vectors++;
        if (grant !== 4'b0100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: grant=%b busy=%b want 0100/1", grant, busy);
        end
        tick();
        vectors++;
        if (LED !== 4'hA) begin
            miscompares++;
            $display("FAIL single_led: LED=%h want a", LED);
        end
        req = 4'b0000;
        tick();
        vectors++;
        if (grant !== 4'b0000 || busy !== 1'b0 || LED !== 4'hA) begin
            miscompares++;
            $display("FAIL single_release: grant=%b busy=%b LED=%h want 0000/0/a", grant, busy, LED);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (grant !== 4'b0000 || LED !== m_led) begin
                miscompares++;
                $display("FAIL single_idle: grant=%b LED=%h want 0000/%h", grant, LED, m_led);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] hist [20];
        logic [3:0] last;
        logic [3:0] exp;
        int run;
        apply_reset();
        pattern = {$urandom} & 32'hFFFF;
        req = 4'b1111;
        run = 0;
        last = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            hist[k] = grant;
            vectors++;
            if (grant !== exp_grant() || LED !== m_led || busy !== exp_busy()) begin
                miscompares++;
                $display("FAIL rr_model: grant=%b LED=%h busy=%b want %b/%h/%b",
                         grant, LED, busy, exp_grant(), m_led, exp_busy());
            end
            if (grant != 4'b0000) begin
                run  = (grant == last) ? run + 1 : 1;
                last = grant;
                if (run == 3) req = req & ~grant;
            end else begin
                req  = 4'b1111;
                last = '0;
                run  = 0;
            end
        end
        for (int k = 0; k < 20; k++) begin
            exp = ((k % 4) < 3) ? 4'(1 << ((k / 4) % 4)) : 4'b0000;
            vectors++;
            if (hist[k] !== exp) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: grant=%b want %b", k, hist[k], exp);
            end
        end
    endtask

    task automatic test_preempt();
        logic [3:0] hist [20];
        logic [3:0] exp;
        apply_reset();
        pattern = {$urandom} & 32'hFFFF;
        req = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            tick();
            hist[k] = grant;
            vectors++;
            if (grant !== exp_grant() || LED !== m_led || busy !== exp_busy()) begin
                miscompares++;
                $display("FAIL preempt_model: grant=%b LED=%h busy=%b want %b/%h/%b",
                         grant, LED, busy, exp_grant(), m_led, exp_busy());
            end
            if (k == 1) req = 4'b1001;
        end
        for (int k = 0; k < 17; k++) begin
            exp = (k < 8) ? 4'b0001 : (k == 8) ? 4'b0000 : 4'b1000;
            vectors++;
            if (hist[k] !== exp) begin
                miscompares++;
                $display("FAIL preempt_seq[%0d]: grant=%b want %b", k, hist[k], exp);
            end
        end
    endtask

    task automatic test_lone_owner();
        apply_reset();
        pattern = {$urandom} & 32'hFFFF;
        req = 4'b0010;
        for (int k = 0; k < 50; k++) begin
            tick();
            vectors++;
            if (grant !== 4'b0010 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL lone_owner[%0d]: grant=%b busy=%b want 0010/1", k, grant, busy);
            end
        end
        vectors++;
        if (LED !== pattern[7:4]) begin
            miscompares++;
            $display("FAIL lone_led: LED=%h want %h", LED, pattern[7:4]);
        end
    endtask

    task automatic test_idle_heartbeat();
        int lit;
        apply_reset();
        req = '0;
        lit = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (LED != 4'h0) lit++;
            vectors++;
            if (LED !== m_led) begin
                miscompares++;
                $display("FAIL idle_hb: LED=%h want %h", LED, m_led);
            end
        end
`ifdef LED_ARB_DIM_EN
        vectors++;
        if (lit > 16) begin
            miscompares++;
            $display("FAIL dim_duty: lit=%0d want <=16", lit);
        end
`endif
    endtask

    task automatic test_random();
        int left;
        apply_reset();
        left = 0;
        for (int k = 0; k < 400; k++) begin
            if (left == 0) begin
                req  = 4'($urandom_range(0, 15));
                left = $urandom_range(1, 14);
            end
            left--;
            pattern = {$urandom} & 32'hFFFF;
            tick();
            vectors++;
            if (grant !== exp_grant() || LED !== m_led || busy !== exp_busy()) begin
                miscompares++;
                $display("FAIL random[%0d]: grant=%b LED=%h busy=%b want %b/%h/%b",
                         k, grant, LED, busy, exp_grant(), m_led, exp_busy());
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req = '0;
        pattern = '0;
        m_owner = -1; m_phase = 0; m_ptr = 0; m_hold = 0; m_hb = 0; m_led = 4'h0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_preempt();
        test_lone_owner();
        test_idle_heartbeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Round-robin arbiter sharing the board's LED bank among up to NUM_REQ on-chip status sources. Each source requests ownership and supplies an LED pattern. The arbiter grants one owner at a time, forces rotation after a maximum hold time when others are waiting, and shows a free-running heartbeat pattern when nobody owns the bank. It sits between the status sources and the top-level `LED` pins, in the single `CLK_66MHZ` domain.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `LED_W`, 4: LED bank width.
- `MAX_HOLD`, 66_000_000: cycles an owner may hold the bank while another requester is pending (≥2).
- `HB_W`, 27: heartbeat counter width. The idle pattern is `hb[HB_W-1 -: LED_W]`.

Ports:
- `CLK_66MHZ` in 1: the only clock.
- `USER_RESET_N` in 1: reset is synchronous and active-low.
- `req` in NUM_REQ: per-source ownership request, level-held.
- `pattern` in NUM_REQ*LED_W: flattened patterns; source i owns bits `[i*LED_W +: LED_W]`.
- `grant` out NUM_REQ: one-hot owner indication, registered.
- `busy` out 1: high while in GRANT.
- `LED` out LED_W: registered LED drive.

## Operation
- Reset values (USER_RESET_N low at an edge):
  - `grant`=0, `busy`=0, `LED`=0.
  - state=IDLE, rr pointer=0, hold counter=0, heartbeat counter=0.
- Reset applied mid-grant: all of the above take their reset values at that edge. No partial release.
- Heartbeat counter `hb` increments every cycle and wraps modulo 2^HB_W.
- States:
  - IDLE: if any `req` bit is set, pick the winner, load `grant`, clear the hold counter, go to GRANT. Otherwise stay.
  - GRANT: the owner is the bit set in `grant`.
    - Owner's `req` low: go to RELEASE.
    - Hold counter == MAX_HOLD-1 and another `req` bit is set: go to RELEASE (preemption).
    - Otherwise the hold counter increments, saturating at MAX_HOLD-1.
  - RELEASE: `grant`=0 for exactly one cycle. Then re-arbitrate as in IDLE, going to GRANT or IDLE.
- Round-robin rule:
  - The search starts at pointer p and goes upward, modulo NUM_REQ.
  - On each grant, p becomes winner+1, wrapping modulo NUM_REQ.
  - A preempted owner that still requests competes normally and has lowest priority next round.
- Owner drop and timeout in the same cycle: treated as a normal release. Same single-cycle RELEASE.
- The lone requester never loses the bank: the timeout only preempts when another request is pending.
- LED register, loaded every cycle:
  - In GRANT: owner's `pattern` slice.
  - In IDLE and RELEASE: heartbeat bits.

## Timing
- `req` sampled high at edge k (state IDLE) → `grant`/`busy` high after edge k.
- The LED register loads the owner's pattern at edge k+1, so `LED` = owner pattern from edge k+1 onward, one-cycle lag.
- Owner drops `req` before edge m → `grant`=0 after m (RELEASE) → next `grant` after m+1.
- Preemption: the hold counter reaches MAX_HOLD-1 at edge t with another request pending → `grant`=0 after t+1, next owner after t+2.
- Worst-case wait for any continuously requesting source: (NUM_REQ-1)×(MAX_HOLD+2) cycles.

## Configuration
- Macro `LED_ARB_DIM_EN`.
- Defined: the heartbeat pattern is dimmed to 25% duty. In IDLE and RELEASE the LED loads the heartbeat bits only when `hb[1:0]`==2'b00, and 0 otherwise. The owner pattern is never dimmed.
- Undefined: the heartbeat is shown at full duty. No extra logic.

## Structure
- Package `led_arb_pkg` holds:
  - the state enum (IDLE, GRANT, RELEASE);
  - the LED_W default;
  - a function returning the next rr pointer.
- Sub-module `rr_pick`: combinational; inputs `req` and pointer p; outputs the one-hot winner and a valid flag. Instantiated once.
- Everything else (FSM, hold counter, heartbeat, LED register) lives in `led_arbiter`.

## Test plan
Sim params for all scenarios: NUM_REQ=4, LED_W=4, MAX_HOLD=8, HB_W=6.
- Reset: hold USER_RESET_N low for 3 cycles during an active grant → `grant`=0, `LED`=0, `busy`=0. After release, `LED` tracks `hb[5:2]`.
- Single grant: `req`=4'b0100, pattern2=4'hA → `grant`=4'b0100 one edge later, `LED`=4'hA the edge after. Drop req → one RELEASE cycle, then IDLE heartbeat.
- Round-robin: `req`=4'b1111 held, all sources drop req after 3 cycles of ownership → grant order 0,1,2,3,0, each separated by one zero-`grant` cycle.
- Preemption: req0 held forever, req3 asserted at cycle 2 → `grant`=0001 for exactly 8 cycles, one gap cycle, then `grant`=1000.
- Lone owner with no timeout: req1 held for 50 cycles alone → `grant`=0010 continuously, no gap cycles.
- Dim mode (`LED_ARB_DIM_EN` defined), `req`=0 → `LED` nonzero at most 1 cycle in 4, matching `hb[5:2]` on those cycles.
